sdram_power_sequencer: RTL and testbench

//  Power and clock sequencer for the external SDRAM, clocked by clk_dram_out.

---
 rtl/sdram_power_sequencer.sv | 105 ++++++++++
 tb/tb_sdram_power_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sdram_power_sequencer.sv
// Power/clock sequencer for the external SDRAM: power up, settle, free-run clock, then hand
// clock control to the handler; shutdown stops the clock before removing power.
module sdram_power_sequencer #(
  parameter int CNT_W             = 16,
  parameter int PWR_SETTLE_CYCLES = 2000,
  parameter int CLK_STABLE_CYCLES = 10000,
  parameter int CLK_STOP_CYCLES   = 16,
  parameter int PWR_OFF_CYCLES    = 5000
) (
  input  logic       clk_dram_out,
  input  logic       irst,
  input  logic       enable,
  input  logic       clk_oe_req,
  output logic       pwren,
  output logic       clk_oe,
  output logic       ready,
  output logic [2:0] state
);

  localparam logic [2:0] S_OFF        = 3'd0;
  localparam logic [2:0] S_PWR_SETTLE = 3'd1;
  localparam logic [2:0] S_CLK_STABLE = 3'd2;
  localparam logic [2:0] S_RUN        = 3'd3;
  localparam logic [2:0] S_CLK_STOP   = 3'd4;
  localparam logic [2:0] S_PWR_DOWN   = 3'd5;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(PWR_SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LD = CNT_W'(CLK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LD   = CNT_W'(CLK_STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LD    = CNT_W'(PWR_OFF_CYCLES - 1);

  logic             en_meta_q, en_s_q;
  logic             req_meta_q, req_s_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwren_q, pwren_d;
  logic             clk_oe_q, clk_oe_d;
  logic             ready_q, ready_d;

  // State register: also holds synchronisers, counter and registered outputs.
  always_ff @(posedge clk_dram_out or posedge irst) begin
    if (irst) begin
      en_meta_q  <= 1'b0;
      en_s_q     <= 1'b0;
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      state_q    <= S_OFF;
      cnt_q      <= '0;
      pwren_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      en_meta_q  <= enable;
      en_s_q     <= en_meta_q;
      req_meta_q <= clk_oe_req;
      req_s_q    <= req_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pwren_q    <= pwren_d;
      clk_oe_q   <= clk_oe_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state and counter. Shutdown takes priority over dwell expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:        if (en_s_q) state_d = S_PWR_SETTLE;
      S_PWR_SETTLE: if (!en_s_q) state_d = S_PWR_DOWN;
                    else if (cnt_q == '0) state_d = S_CLK_STABLE;
      S_CLK_STABLE: if (!en_s_q) state_d = S_CLK_STOP;
                    else if (cnt_q == '0) state_d = S_RUN;
      S_RUN:        if (!en_s_q) state_d = S_CLK_STOP;
      S_CLK_STOP:   if (cnt_q == '0) state_d = S_PWR_DOWN;
      S_PWR_DOWN:   if (cnt_q == '0) state_d = S_OFF;
      default:      state_d = S_OFF;
    endcase

    cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    if (state_d != state_q) begin
      case (state_d)
        S_PWR_SETTLE: cnt_d = SETTLE_LD;
        S_CLK_STABLE: cnt_d = STABLE_LD;
        S_CLK_STOP:   cnt_d = STOP_LD;
        S_PWR_DOWN:   cnt_d = OFF_LD;
        default:      cnt_d = '0;
      endcase
    end
  end

  // Outputs decoded from the next state so they switch on the same edge as state.
  always_comb begin
    pwren_d  = (state_d == S_PWR_SETTLE) || (state_d == S_CLK_STABLE) ||
               (state_d == S_RUN)        || (state_d == S_CLK_STOP);
    clk_oe_d = (state_d == S_CLK_STABLE) || ((state_d == S_RUN) && req_s_q);
    ready_d  = (state_d == S_RUN);
  end

  assign pwren  = pwren_q;
  assign clk_oe = clk_oe_q;
  assign ready  = ready_q;
  assign state  = state_q;

endmodule

// File: tb/tb_sdram_power_sequencer.sv
// Bench for sdram_power_sequencer: table of {inputs, hold edges, expected outputs} records
// applied through a scoreboard queue, plus a hand-written asynchronous reset check.
module tb_sdram_power_sequencer;

  logic       clk_dram_out;
  logic       irst;
  logic       enable;
  logic       clk_oe_req;
  logic       pwren;
  logic       clk_oe;
  logic       ready;
  logic [2:0] state;

  sdram_power_sequencer #(
    .CNT_W(4), .PWR_SETTLE_CYCLES(4), .CLK_STABLE_CYCLES(8),
    .CLK_STOP_CYCLES(2), .PWR_OFF_CYCLES(6)
  ) dut (
    .clk_dram_out(clk_dram_out),
    .irst(irst),
    .enable(enable),
    .clk_oe_req(clk_oe_req),
    .pwren(pwren),
    .clk_oe(clk_oe),
    .ready(ready),
    .state(state)
  );

  initial clk_dram_out = 1'b0;
  always #5 clk_dram_out = ~clk_dram_out;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic       req;
    int         n;
    logic       pw;
    logic       oe;
    logic       rdy;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(input string name, input logic rst, input logic en,
                              input logic req, input int n, input logic pw,
                              input logic oe, input logic rdy, input logic [2:0] st);
    vec_t v;
    v.name = name; v.rst = rst; v.en = en; v.req = req; v.n = n;
    v.pw = pw; v.oe = oe; v.rdy = rdy; v.st = st;
    tbl.push_back(v);
  endfunction

  task automatic check();
    vec_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: no expected record queued");
      return;
    end
    e = sb.pop_front();
    if ({pwren, clk_oe, ready, state} !== {e.pw, e.oe, e.rdy, e.st}) begin
      n_err++;
      $display("FAIL %s @%0t: got pwren=%b clk_oe=%b ready=%b state=%0d, want pwren=%b clk_oe=%b ready=%b state=%0d",
               e.name, $time, pwren, clk_oe, ready, state, e.pw, e.oe, e.rdy, e.st);
    end
  endtask

  // Drive inputs, let n rising edges pass, then compare on the following falling edge.
  task automatic run_vec(input vec_t v);
    irst       = v.rst;
    enable     = v.en;
    clk_oe_req = v.req;
    sb.push_back(v);
    repeat (v.n) @(posedge clk_dram_out);
    @(negedge clk_dram_out);
    check();
  endtask

  initial begin
    vec_t v;
    irst = 1'b1; enable = 1'b0; clk_oe_req = 1'b0;

    //   name              rst en req  n  pw oe rdy st
    add("reset_hold",       1, 0, 0,  2, 0, 0, 0,  0);
    add("idle_no_enable",   0, 0, 0,  2, 0, 0, 0,  0);
    // power-up: pwren @3, clk_oe @7, ready @15
    add("up_sync_delay",    0, 1, 1,  2, 0, 0, 0,  0);
    add("up_pwren_e3",      0, 1, 1,  1, 1, 0, 0,  1);
    add("up_settle_e6",     0, 1, 1,  3, 1, 0, 0,  1);
    add("up_clkoe_e7",      0, 1, 1,  1, 1, 1, 0,  2);
    add("up_stable_e14",    0, 1, 1,  7, 1, 1, 0,  2);
    add("up_ready_e15",     0, 1, 1,  1, 1, 1, 1,  3);
    // clock request follows after 3 edges in RUN
    add("req_low_e2",       0, 1, 0,  2, 1, 1, 1,  3);
    add("req_low_e3",       0, 1, 0,  1, 1, 0, 1,  3);
    add("req_high_e2",      0, 1, 1,  2, 1, 0, 1,  3);
    add("req_high_e3",      0, 1, 1,  1, 1, 1, 1,  3);
    // shutdown from RUN: clk_oe/ready @T+3, pwren @T+5, OFF @T+11
    add("dn_sync_t2",       0, 0, 1,  2, 1, 1, 1,  3);
    add("dn_clkstop_t3",    0, 0, 1,  1, 1, 0, 0,  4);
    add("dn_clkstop_t4",    0, 0, 1,  1, 1, 0, 0,  4);
    add("dn_pwrdown_t5",    0, 0, 1,  1, 0, 0, 0,  5);
    add("dn_pwrdown_t10",   0, 0, 1,  5, 0, 0, 0,  5);
    add("dn_off_t11",       0, 0, 1,  1, 0, 0, 0,  0);
    add("dn_off_idle",      0, 0, 1,  3, 0, 0, 0,  0);
    // abort in PWR_SETTLE, en_s drops on the same cycle the dwell ends
    add("abort_settle_c1",  0, 1, 1,  3, 1, 0, 0,  1);
    add("abort_settle_c2",  0, 1, 1,  1, 1, 0, 0,  1);
    add("abort_sync",       0, 0, 1,  2, 1, 0, 0,  1);
    add("abort_to_pwrdown", 0, 0, 1,  1, 0, 0, 0,  5);
    add("abort_pwrdown",    0, 0, 1,  5, 0, 0, 0,  5);
    add("abort_off",        0, 0, 1,  1, 0, 0, 0,  0);
    // enable glitch in CLK_STABLE: full STOP + OFF dwell before restart
    add("glitch_settle",    0, 1, 1,  3, 1, 0, 0,  1);
    add("glitch_stable",    0, 1, 1,  4, 1, 1, 0,  2);
    add("glitch_clkstop",   0, 0, 1,  3, 1, 0, 0,  4);
    add("glitch_pwrdown",   0, 1, 1,  2, 0, 0, 0,  5);
    add("glitch_pwrdown_e", 0, 1, 1,  5, 0, 0, 0,  5);
    add("glitch_off",       0, 1, 1,  1, 0, 0, 0,  0);
    add("glitch_restart",   0, 1, 1,  1, 1, 0, 0,  1);
    add("glitch_stable2",   0, 1, 1,  4, 1, 1, 0,  2);
    add("glitch_run",       0, 1, 1,  8, 1, 1, 1,  3);

    @(negedge clk_dram_out);
    foreach (tbl[i]) run_vec(tbl[i]);

    // asynchronous reset mid-cycle while in RUN: outputs drop without a clock edge
    #2;
    v.name = "async_reset"; v.rst = 1'b1; v.en = 1'b1; v.req = 1'b1; v.n = 0;
    v.pw = 1'b0; v.oe = 1'b0; v.rdy = 1'b0; v.st = 3'd0;
    irst = 1'b1;
    sb.push_back(v);
    #1;
    check();

    v.name = "rst_held"; v.n = 2;
    run_vec(v);
    // release with enable high: full power-up repeats
    v.name = "re_sync"; v.rst = 1'b0; v.n = 2;
    run_vec(v);
    v.name = "re_pwren"; v.n = 1; v.pw = 1'b1; v.st = 3'd1;
    run_vec(v);
    v.name = "re_clkoe"; v.n = 4; v.oe = 1'b1; v.st = 3'd2;
    run_vec(v);
    v.name = "re_ready"; v.n = 8; v.rdy = 1'b1; v.st = 3'd3;
    run_vec(v);

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d records, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
